// File: rtl/bin2bcd_hex.sv
// -----------------------------------------------------------------------------
// bin2bcd_hex
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) that feeds
//   the per-digit 7-segment decoders. A WIDTH-bit value is captured on a start
//   strobe. WIDTH clocks later the module presents DIGITS BCD nibbles, one
//   display enable per digit and an overflow flag, together with a one-cycle
//   done pulse.
//
//   Optional feature macro: BIN2BCD_BLANK_EN
//     defined   -> leading-zero blanking on en (en[0] always 1, others drop
//                  while the digit and all more-significant digits are 0;
//                  overflow forces all ones); reset value of en = 0...01.
//     undefined -> en is all ones at reset and after every conversion.
//
// Parameters
//   WIDTH   binary input width, 2^WIDTH <= 10^(DIGITS+1)
//   DIGITS  number of BCD output digits
//
// Ports
//   c      in   clock
//   rst    in   synchronous active-high reset
//   start  in   conversion request, only honoured while idle
//   din    in   binary value, captured on the edge that accepts start
//   busy   out  conversion in progress
//   done   out  one-cycle pulse, bcd/en/ovf carry a fresh result
//   bcd    out  digit i in bcd[4i+3:4i], digit 0 least significant
//   en     out  per-digit display enable
//   ovf    out  last din exceeded 10^DIGITS-1
// -----------------------------------------------------------------------------
module bin2bcd_hex #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  c,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     en,
  output logic                  ovf
);

  // Scratch holds one extra nibble so values up to 10^(DIGITS+1)-1 fit and
  // the overflow digit can be inspected.
  localparam int SW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] EN_RST = DIGITS'(1);
`else
  localparam logic [DIGITS-1:0] EN_RST = '1;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic                w_finish;

  logic [WIDTH-1:0]    r_shift;
  logic [SW-1:0]       r_scratch;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_en;

  logic [SW-1:0]       w_adj;
  logic [SW-1:0]       w_scratch_nxt;
  logic                w_last;
  logic                w_ovf;
  logic [DIGITS-1:0]   w_en_final;

  // ---------------------------------------------------------------------------
  // Add-3 correction: every nibble >= 5 is pre-adjusted so that the following
  // left shift carries correctly into the next decimal digit.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // update; a path that leaves it unassigned would infer a latch.
    w_adj = r_scratch;
    for (int i = 0; i <= DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_scratch_nxt = {w_adj[SW-2:0], r_shift[WIDTH-1]};
  assign w_last        = (r_cnt == CW'(1));
  // A bit shifted out of the scratch cannot occur within the width
  // constraint, but if it ever did the result is certainly out of range.
  assign w_ovf         = (|w_scratch_nxt[SW-1 -: 4]) | w_adj[SW-1];

`ifdef BIN2BCD_BLANK_EN
  // Scan from the most-significant digit downward; a digit stays lit once any
  // digit at or above it is non-zero. Overflow lights everything.
  always_comb begin
    logic w_any;
    w_any         = 1'b0;
    w_en_final    = '0;
    w_en_final[0] = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_any         = w_any | (|w_scratch_nxt[4*i +: 4]);
      w_en_final[i] = w_any | w_ovf;
    end
  end
`else
  assign w_en_final = '1;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge c) begin
    // NOTE: state elements are written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge c) begin
    if (rst) begin
      // NOTE: the working registers are reset as well as the outputs; they are
      // few and this keeps simulation free of X after an aborted conversion.
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_en      <= EN_RST;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shift   <= din;
        r_scratch <= '0;
        r_cnt     <= CW'(WIDTH);
        r_busy    <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
        r_scratch <= w_scratch_nxt;
        r_cnt     <= r_cnt - CW'(1);
        if (w_finish) begin
          r_bcd  <= w_scratch_nxt[4*DIGITS-1:0];
          r_ovf  <= w_ovf;
          r_en   <= w_en_final;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign en   = r_en;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_hex.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_hex
//   Directed-vector bench for bin2bcd_hex (WIDTH=14, DIGITS=4). Expected
//   values are hand-computed decimal conversions; enable expectations follow
//   the BIN2BCD_BLANK_EN build option.
// -----------------------------------------------------------------------------
module tb_bin2bcd_hex;

  logic        c;
  logic        rst;
  logic        start;
  logic [13:0] din;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  en;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef BIN2BCD_BLANK_EN
  localparam logic [3:0] EN_RST = 4'b0001;
  localparam logic [3:0] EN_0   = 4'b0001;
  localparam logic [3:0] EN_42  = 4'b0011;
  localparam logic [3:0] EN_7   = 4'b0001;
`else
  localparam logic [3:0] EN_RST = 4'b1111;
  localparam logic [3:0] EN_0   = 4'b1111;
  localparam logic [3:0] EN_42  = 4'b1111;
  localparam logic [3:0] EN_7   = 4'b1111;
`endif

  bin2bcd_hex #(.WIDTH(14), .DIGITS(4)) dut (
    .c     (c),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .en    (en),
    .ovf   (ovf)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge c);
    #1;
  endtask

  // Pulse start for one cycle with value v, then wait (bounded) for done.
  // lat = edges after the accepting edge until done is seen (40 = timeout);
  // bc  = number of post-edge samples with busy high before done.
  task automatic run_conv(input logic [13:0] v, output int lat, output int bc);
    start = 1'b1;
    din   = v;
    step();
    start = 1'b0;
    din   = ~v;
    lat   = 0;
    bc    = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    step();
    step();
    checks++;
    if ({busy, done, ovf, bcd, en} !== {1'b0, 1'b0, 1'b0, 16'h0000, EN_RST}) begin
      errors++;
      $display("FAIL reset busy=%b done=%b ovf=%b bcd=%h en=%b expected 0 0 0 0000 %b",
               busy, done, ovf, bcd, en, EN_RST);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bc;
    run_conv(14'd1234, lat, bc);
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL basic_latency got %0d expected 14", lat);
    end
    checks++;
    if (bc !== 14) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d expected 14", bc);
    end
    checks++;
    if ({busy, bcd, en, ovf} !== {1'b0, 16'h1234, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL basic_result busy=%b bcd=%h en=%b ovf=%b expected 0 1234 1111 0",
               busy, bcd, en, ovf);
    end
    step();
    checks++;
    if ({done, bcd} !== {1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL done_pulse_hold done=%b bcd=%h expected 0 1234", done, bcd);
    end
  endtask

  task automatic test_values();
    int lat, bc;
    run_conv(14'd0, lat, bc);
    checks++;
    if ({lat, bcd, en, ovf} !== {32'd14, 16'h0000, EN_0, 1'b0}) begin
      errors++;
      $display("FAIL zero lat=%0d bcd=%h en=%b ovf=%b expected 14 0000 %b 0",
               lat, bcd, en, ovf, EN_0);
    end
    run_conv(14'd16383, lat, bc);
    checks++;
    if ({bcd, en, ovf} !== {16'h6383, 4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL max16383 bcd=%h en=%b ovf=%b expected 6383 1111 1", bcd, en, ovf);
    end
    run_conv(14'd9999, lat, bc);
    checks++;
    if ({bcd, en, ovf} !== {16'h9999, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL v9999 bcd=%h en=%b ovf=%b expected 9999 1111 0", bcd, en, ovf);
    end
    run_conv(14'd10000, lat, bc);
    checks++;
    if ({bcd, en, ovf} !== {16'h0000, 4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL v10000 bcd=%h en=%b ovf=%b expected 0000 1111 1", bcd, en, ovf);
    end
    run_conv(14'd8051, lat, bc);
    checks++;
    if ({bcd, en, ovf} !== {16'h8051, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL v8051 bcd=%h en=%b ovf=%b expected 8051 1111 0", bcd, en, ovf);
    end
  endtask

  task automatic test_start_held();
    int lat, bc, n, dones;
    dones = 0;
    run_conv(14'd42, lat, bc);
    if (done === 1'b1) dones++;
    checks++;
    if ({bcd, en, ovf} !== {16'h0042, EN_42, 1'b0}) begin
      errors++;
      $display("FAIL v42 bcd=%h en=%b ovf=%b expected 0042 %b 0", bcd, en, ovf, EN_42);
    end
    // start issued in the done cycle and then held through the whole conversion
    start = 1'b1;
    din   = 14'd7;
    step();
    din = 14'd1234;
    n   = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (done === 1'b1) dones++;
    start = 1'b0;
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL held_latency got %0d expected 14", n);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL held_done_count got %0d expected 2", dones);
    end
    checks++;
    if ({bcd, en, ovf} !== {16'h0007, EN_7, 1'b0}) begin
      errors++;
      $display("FAIL v7 bcd=%h en=%b ovf=%b expected 0007 %b 0", bcd, en, ovf, EN_7);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, gap;
    run_conv(14'd1234, lat, bc);
    start = 1'b1;
    din   = 14'd5678;
    step();
    start = 1'b0;
    din   = 14'd0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b expected 1 0", busy, done);
    end
    gap = 1;
    while (done !== 1'b1 && gap < 40) begin
      step();
      gap++;
    end
    checks++;
    if (gap !== 15) begin
      errors++;
      $display("FAIL b2b_gap got %0d expected 15", gap);
    end
    checks++;
    if ({bcd, en, ovf} !== {16'h5678, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL v5678 bcd=%h en=%b ovf=%b expected 5678 1111 0", bcd, en, ovf);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones;
    start = 1'b1;
    din   = 14'd1234;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy, done, ovf, bcd, en} !== {1'b0, 1'b0, 1'b0, 16'h0000, EN_RST}) begin
      errors++;
      $display("FAIL abort_reset busy=%b done=%b ovf=%b bcd=%h en=%b expected 0 0 0 0000 %b",
               busy, done, ovf, bcd, en, EN_RST);
    end
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done === 1'b1) dones++;
    end
    checks++;
    if ({dones, busy} !== {32'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_no_done dones=%0d busy=%b expected 0 0", dones, busy);
    end
    run_conv(14'd1000, lat, bc);
    checks++;
    if ({lat, bcd, en, ovf} !== {32'd14, 16'h1000, 4'b1111, 1'b0}) begin
      errors++;
      $display("FAIL after_abort lat=%0d bcd=%h en=%b ovf=%b expected 14 1000 1111 0",
               lat, bcd, en, ovf);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    test_reset();
    test_basic();
    test_values();
    test_start_held();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
